benes_8_router: RTL and testbench
=================================

// Module: benes_8_router
// PURPOSE
//  Switch-setting controller for an 8x8 rearrangeable Benes network: 5 columns of 2x2 switches, 4 switches per column.
//  Accepts a destination permutation (input i -> output mp_i).
//  Computes all 20 switch controls with the looping algorithm, iteratively over a fixed number of cycles.
//  Sits beside the data-path switch fabric and drives its control bus.
// PARAMETERS
//  none (size fixed at N=8, 3-bit addresses, 20 control bits)
// PORTS
//  clk     in   1   rising-edge clock
//  areset  in   1   asynchronous, active-low reset
//  start   in   1   request: sample mp0..mp7 and route; level, sampled in IDLE only
//  mp0..mp7 in  3   destination output index of input 0..7 (must be a permutation)
//  state   out  20  switch controls; 0=bar (straight), 1=cross
//  done    out  1   one-cycle pulse when state has been updated
// BEHAVIOUR
//  Reset (areset=0, async): state=0, done=0, FSM->IDLE, colour/work registers cleared.
//  Wiring / bit map: nibble c = state[4c+3:4c] is column c (0..4). Any reset mid-operation aborts the computation.
//   col0 bit k: input switch k (inputs 2k,2k+1); top out->upper sub in k, bottom->lower sub in k.
//   col4 bit k: output switch k (outputs 2k,2k+1); top in<-upper sub out k, bottom<-lower sub out k.
//   col1..3: bits[1:0] = upper 4x4 subnet switches 0,1; bits[3:2] = lower 4x4 subnet switches 0,1.
//   Each 4x4 subnet is wired recursively in the same way. Its middle column bit0 is its upper 2x2, bit1 its lower 2x2.
//  Colouring rules (colour 0=upper sub, 1=lower sub), for the 8x8 level and again for each 4x4:
//   in i and out mp_i share a colour.
//   Partners (2k,2k+1) always get opposite colours, on both the input and the output side.
//  Loop step (one per cycle):
//   a) Cursor input i gets colour c. out o=mp_i gets c, and out o^1 gets ~c.
//   b) Input j=inv(o^1) gets ~c, and its partner j^1 gets c.
//   c) Next cursor = j^1 if it is uncoloured, else the lowest uncoloured even input with c=0.
//   The first cursor is input 0 with c=0.
//  FSM: IDLE -> L8 (4 cycles) -> L4 (2 cycles) -> WR (1 cycle) -> IDLE.
//   IDLE: on start=1 at an edge, latch mp0..7, build the inverse permutation, then go to L8.
//   L8: colour the 8x8 level, one loop step per cycle.
//    At exit: col0 bit k = ci[2k], col4 bit k = co[2k].
//    ump[k] = mp(upper input of switch k)>>1; dmp[k] likewise for the lower input.
//   L4: route both 4x4 subnets in parallel, one step per cycle.
//    Middle 2x2 bit = 1 iff the sub-sub permutation is swapped.
//   WR: load all 20 bits into state and pulse done=1 for this cycle.
//  Latency: state and done update on the 7th rising edge after the start-sampling edge.
//   state holds its value until the next WR.
//  start while busy (not IDLE) is ignored. start held high re-triggers in the cycle after WR.
//  mp changes after the sampling edge have no effect.
//  Non-permutation input: the FSM still completes with the same latency and pulses done; the state value is unspecified.
// STRUCTURE
//  pkg benes_pkg: N=8, LOGN=3, NSW=20, state enum {IDLE,L8,L4,WR}, column/bit-index constants.
//  Sub-module benes_loop4: 4-input looping colourer, instantiated twice (upper/lower).
//   Takes a 2-bit permutation and produces the 6 switch bits of its subnet in 2 steps.
//  The 8-level loop and the FSM stay in the top module.
// TESTING
//  1 Reset: hold areset=0, then release. Required: state=0, done=0. Toggling start during reset has no effect.
//  2 Identity: mp = 0,1,2,3,4,5,6,7, start 1 cycle. Required: done after 7 edges, state=20'h00000.
//  3 mp = 0,1,4,5,7,6,3,2. Required: state=20'hAAA00.
//  4 Reversal: mp = 7,6,5,4,3,2,1,0. Required: state=20'hFFF00.
//  5 Pulse start again at cycle 3 of case 3. Required: ignored, a single done, state=20'hAAA00.
//  6 Assert areset in cycle 4 of L8. Required: state=0, IDLE immediately.
//    A new start with the identity mapping must then yield 20'h00000.

Source files
------------

// File: rtl/benes_pkg.sv
// Shared definitions for the 8x8 Benes switch-setting controller.
// Holds the network size, the FSM state encodings, the column indices of
// the 20-bit control word and a helper that finds the next free loop start.
package benes_pkg;

   localparam int N    = 8;
   localparam int LOGN = 3;
   localparam int NSW  = 20;

   typedef logic [LOGN-1:0] addr_t;

   // FSM encodings
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] L8   = 2'd1;
   localparam logic [1:0] L4   = 2'd2;
   localparam logic [1:0] WR   = 2'd3;

   // Last value of the step counter in each looping phase
   localparam logic [1:0] L8_LAST = 2'd3;
   localparam logic [1:0] L4_LAST = 2'd1;

   // Nibble index of each switch column inside the control word
   localparam int COL_IN      = 0;
   localparam int COL_SUB_IN  = 1;
   localparam int COL_MID     = 2;
   localparam int COL_SUB_OUT = 3;
   localparam int COL_OUT     = 4;

   // Lowest even input whose colour is still open; a loop always restarts
   // on an even input because partners are coloured together.
   function automatic addr_t first_free_even(input logic [N-1:0] used,
                                             input addr_t fallback);
      addr_t r;
      r = fallback;
      for (int e = N - 2; e >= 0; e -= 2) begin
         if (!used[e]) r = addr_t'(e);
      end
      return r;
   endfunction

endpackage

// File: rtl/benes_loop4.sv
// Looping colourer for one 4x4 Benes subnet.
// Colours the four inputs/outputs in two loop steps and reports the six
// switch bits of the subnet.
// Ports:
//   clk, areset : clock, asynchronous active-low reset
//   clear       : zero the colouring (held while the 8x8 level is routed)
//   step        : perform one loop step this cycle
//   perm        : 4 x 2-bit permutation, perm[2k+1:2k] = destination of input k
//   sw          : [1:0] input switches, [3:2] middle 2x2 (bit2 upper, bit3 lower),
//                 [5:4] output switches
module benes_loop4
   import benes_pkg::*;
(
   input  logic       clk,
   input  logic       areset,
   input  logic       clear,
   input  logic       step,
   input  logic [7:0] perm,
   output logic [5:0] sw
);

   logic [1:0] p   [4];
   logic [1:0] inv [4];
   logic [3:0] ci, co, vi;
   logic [3:0] ci_n, co_n, vi_n;
   logic [1:0] cur, cur_n;
   logic       cc, cc_n;
   logic [1:0] o, o1, j, j1;
   logic [1:0] up_in, lo_in;

   // Unpack the permutation and build its inverse
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         p[i]   = perm[2*i +: 2];
         inv[i] = 2'd0;
      end
      for (int i = 0; i < 4; i++) begin
         inv[p[i]] = 2'(i);
      end
   end

   // One loop step: colour the cursor, its output pair and the input that
   // feeds the partner output, then follow the loop or start a new one
   always_comb begin
      o    = p[cur];
      o1   = o ^ 2'd1;
      j    = inv[o1];
      j1   = j ^ 2'd1;
      ci_n = ci;
      co_n = co;
      vi_n = vi;
      ci_n[cur] = cc;
      vi_n[cur] = 1'b1;
      co_n[o]   = cc;
      co_n[o1]  = ~cc;
      ci_n[j]   = ~cc;
      vi_n[j]   = 1'b1;
      ci_n[j1]  = cc;
      vi_n[j1]  = 1'b1;
      cc_n      = cc;
      cur_n     = cur;
      if (!vi[j1] && (j1 != cur)) begin
         cur_n = j1;
      end else begin
         cc_n = 1'b0;
         if (!vi_n[0])      cur_n = 2'd0;
         else if (!vi_n[2]) cur_n = 2'd2;
      end
   end

   // Colouring registers: cleared before each use, advanced one step per cycle
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         ci  <= '0;
         co  <= '0;
         vi  <= '0;
         cur <= '0;
         cc  <= 1'b0;
      end else if (clear) begin
         ci  <= '0;
         co  <= '0;
         vi  <= '0;
         cur <= '0;
         cc  <= 1'b0;
      end else if (step) begin
         ci  <= ci_n;
         co  <= co_n;
         vi  <= vi_n;
         cur <= cur_n;
         cc  <= cc_n;
      end
   end

   // A middle 2x2 is crossed when its input from switch 0 heads to output 1
   always_comb begin
      up_in = ci[0] ? 2'd1 : 2'd0;
      lo_in = ci[0] ? 2'd0 : 2'd1;
      sw[1:0] = {ci[2], ci[0]};
      sw[2]   = p[up_in][1];
      sw[3]   = p[lo_in][1];
      sw[5:4] = {co[2], co[0]};
   end

endmodule

// File: rtl/benes_8_router.sv
// Switch-setting controller for an 8x8 rearrangeable Benes network.
// Samples a destination permutation, colours the 8x8 level with the looping
// algorithm (4 steps), routes both 4x4 subnets in parallel (2 steps) and
// writes all 20 switch controls at once.
// Ports:
//   clk      : rising-edge clock
//   areset   : asynchronous active-low reset
//   start    : route request, sampled only in IDLE
//   mp0..mp7 : destination output of input 0..7
//   state    : 20 switch controls, nibble c = column c, 0=bar 1=cross
//   done     : one-cycle pulse when state has been updated
module benes_8_router
   import benes_pkg::*;
(
   input  logic           clk,
   input  logic           areset,
   input  logic           start,
   input  logic [2:0]     mp0,
   input  logic [2:0]     mp1,
   input  logic [2:0]     mp2,
   input  logic [2:0]     mp3,
   input  logic [2:0]     mp4,
   input  logic [2:0]     mp5,
   input  logic [2:0]     mp6,
   input  logic [2:0]     mp7,
   output logic [NSW-1:0] state,
   output logic           done
);

   addr_t          mp_in [N];
   addr_t          inv_c [N];
   addr_t          mpr   [N];
   addr_t          inv   [N];
   logic [N-1:0]   ci, co, vi;
   logic [N-1:0]   ci_n, co_n, vi_n;
   addr_t          cur, cur_n;
   logic           cc, cc_n;
   addr_t          o, o1, j, j1;
   logic [1:0]     fsm;
   logic [1:0]     cnt;
   logic [7:0]     ump, dmp;
   logic [5:0]     up_sw, lo_sw;
   logic [NSW-1:0] state_c;

   // Gather the mapping inputs and build the inverse permutation
   always_comb begin
      mp_in[0] = mp0;
      mp_in[1] = mp1;
      mp_in[2] = mp2;
      mp_in[3] = mp3;
      mp_in[4] = mp4;
      mp_in[5] = mp5;
      mp_in[6] = mp6;
      mp_in[7] = mp7;
      for (int i = 0; i < N; i++) begin
         inv_c[i] = '0;
      end
      for (int i = 0; i < N; i++) begin
         inv_c[mp_in[i]] = addr_t'(i);
      end
   end

   // One 8x8 loop step; a loop closes when the partner input was already
   // coloured, and the next loop then starts on a free even input with colour 0
   always_comb begin
      o    = mpr[cur];
      o1   = o ^ 3'd1;
      j    = inv[o1];
      j1   = j ^ 3'd1;
      ci_n = ci;
      co_n = co;
      vi_n = vi;
      ci_n[cur] = cc;
      vi_n[cur] = 1'b1;
      co_n[o]   = cc;
      co_n[o1]  = ~cc;
      ci_n[j]   = ~cc;
      vi_n[j]   = 1'b1;
      ci_n[j1]  = cc;
      vi_n[j1]  = 1'b1;
      cc_n      = cc;
      cur_n     = j1;
      if (vi[j1] || (j1 == cur)) begin
         cc_n  = 1'b0;
         cur_n = first_free_even(vi_n, cur);
      end
   end

   // Sub-permutations: each input switch sends its colour-0 input to the
   // upper subnet and its colour-1 input to the lower one
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         if (ci[2*k]) begin
            ump[2*k +: 2] = mpr[2*k+1][2:1];
            dmp[2*k +: 2] = mpr[2*k][2:1];
         end else begin
            ump[2*k +: 2] = mpr[2*k][2:1];
            dmp[2*k +: 2] = mpr[2*k+1][2:1];
         end
      end
   end

   benes_loop4 u_upper (
      .clk    (clk),
      .areset (areset),
      .clear  (fsm == L8),
      .step   (fsm == L4),
      .perm   (ump),
      .sw     (up_sw)
   );

   benes_loop4 u_lower (
      .clk    (clk),
      .areset (areset),
      .clear  (fsm == L8),
      .step   (fsm == L4),
      .perm   (dmp),
      .sw     (lo_sw)
   );

   // Assemble the control word: outer columns from the 8x8 colouring,
   // inner columns from the two subnets (upper subnet in the low bits)
   always_comb begin
      state_c = '0;
      state_c[4*COL_IN      +: 4] = {ci[6], ci[4], ci[2], ci[0]};
      state_c[4*COL_SUB_IN  +: 4] = {lo_sw[1:0], up_sw[1:0]};
      state_c[4*COL_MID     +: 4] = {lo_sw[3:2], up_sw[3:2]};
      state_c[4*COL_SUB_OUT +: 4] = {lo_sw[5:4], up_sw[5:4]};
      state_c[4*COL_OUT     +: 4] = {co[6], co[4], co[2], co[0]};
   end

   // Controller FSM and 8x8 colouring registers
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         fsm   <= IDLE;
         cnt   <= '0;
         state <= '0;
         done  <= 1'b0;
         ci    <= '0;
         co    <= '0;
         vi    <= '0;
         cur   <= '0;
         cc    <= 1'b0;
         for (int i = 0; i < N; i++) begin
            mpr[i] <= '0;
            inv[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < N; i++) begin
                     mpr[i] <= mp_in[i];
                     inv[i] <= inv_c[i];
                  end
                  ci  <= '0;
                  co  <= '0;
                  vi  <= '0;
                  cur <= '0;
                  cc  <= 1'b0;
                  cnt <= '0;
                  fsm <= L8;
               end
            end
            L8: begin
               ci  <= ci_n;
               co  <= co_n;
               vi  <= vi_n;
               cur <= cur_n;
               cc  <= cc_n;
               cnt <= cnt + 2'd1;
               if (cnt == L8_LAST) begin
                  cnt <= '0;
                  fsm <= L4;
               end
            end
            L4: begin
               cnt <= cnt + 2'd1;
               if (cnt == L4_LAST) begin
                  cnt <= '0;
                  fsm <= WR;
               end
            end
            default: begin
               state <= state_c;
               done  <= 1'b1;
               fsm   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_benes_8_router.sv
// Self-checking bench for benes_8_router.
// Stimulus pushes the expected control word and the expected done edge into
// a scoreboard; a monitor on the falling edge pops and compares on each done.
module tb_benes_8_router;

   logic        clk = 1'b0;
   logic        areset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  mp0, mp1, mp2, mp3, mp4, mp5, mp6, mp7;
   logic [19:0] state;
   logic        done;

   typedef struct {
      logic [19:0] st;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   edge_cnt = 0;

   always #5 clk = ~clk;

   // Count rising edges so done latency can be checked
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   benes_8_router dut (
      .clk    (clk),
      .areset (areset),
      .start  (start),
      .mp0    (mp0),
      .mp1    (mp1),
      .mp2    (mp2),
      .mp3    (mp3),
      .mp4    (mp4),
      .mp5    (mp5),
      .mp6    (mp6),
      .mp7    (mp7),
      .state  (state),
      .done   (done)
   );

   // Compare one value and record the outcome
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic setMap(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7);
      mp0 = 3'(a0); mp1 = 3'(a1); mp2 = 3'(a2); mp3 = 3'(a3);
      mp4 = 3'(a4); mp5 = 3'(a5); mp6 = 3'(a6); mp7 = 3'(a7);
   endtask

   // One-cycle start pulse; mapping is scrambled right after the sampling edge
   task automatic applyStimulus(input string name,
                                input int a0, input int a1, input int a2, input int a3,
                                input int a4, input int a5, input int a6, input int a7,
                                input logic [19:0] req);
      exp_t e;
      @(negedge clk);
      setMap(a0, a1, a2, a3, a4, a5, a6, a7);
      start = 1'b1;
      e.st = req;
      e.cyc = edge_cnt + 8;
      e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      setMap(5, 5, 1, 1, 3, 3, 7, 7);
   endtask

   // Bounded wait for all expected results
   task automatic waitDrain(input string name);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s_timeout: %0d results pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Monitor: every done pulse must match the oldest expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (areset === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_done: state %h, required no done", state);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_state"}, 32'(state), 32'(e.st));
            checkOutput({e.name, "_latency"}, 32'(edge_cnt), 32'(e.cyc));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t e;
      setMap(0, 1, 2, 3, 4, 5, 6, 7);
      // Reset, with start toggling while held
      repeat (3) @(negedge clk) start = ~start;
      start = 1'b0;
      checkOutput("reset_state", 32'(state), 32'h0);
      checkOutput("reset_done", 32'(done), 32'h0);
      @(negedge clk);
      areset = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("idle_state", 32'(state), 32'h0);
      checkOutput("idle_done", 32'(done), 32'h0);

      applyStimulus("identity", 0, 1, 2, 3, 4, 5, 6, 7, 20'h00000);
      waitDrain("identity");

      applyStimulus("map3", 0, 1, 4, 5, 7, 6, 3, 2, 20'hAAA00);
      waitDrain("map3");
      repeat (5) @(negedge clk);
      checkOutput("map3_hold", 32'(state), 32'hAAA00);

      applyStimulus("reversal", 7, 6, 5, 4, 3, 2, 1, 0, 20'hFFF00);
      waitDrain("reversal");

      // Start pulsed while busy must be ignored
      applyStimulus("busy", 0, 1, 4, 5, 7, 6, 3, 2, 20'hAAA00);
      repeat (3) @(negedge clk);
      setMap(7, 6, 5, 4, 3, 2, 1, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDrain("busy");
      repeat (12) @(negedge clk);
      checkOutput("busy_state", 32'(state), 32'hAAA00);

      // Start held high re-triggers right after the write cycle
      @(negedge clk);
      setMap(0, 1, 4, 5, 7, 6, 3, 2);
      start = 1'b1;
      e.st = 20'h0;
      e.cyc = edge_cnt + 8;
      e.name = "retrig_a";
      sb.push_back(e);
      e.st = 20'hFFF00;
      e.cyc = edge_cnt + 16;
      e.name = "retrig_b";
      sb.push_back(e);
      sb[0].st = 20'hAAA00;
      @(posedge clk);
      #1;
      setMap(7, 6, 5, 4, 3, 2, 1, 0);
      repeat (8) @(posedge clk);
      #1;
      start = 1'b0;
      setMap(0, 0, 0, 0, 0, 0, 0, 0);
      waitDrain("retrig");

      // Reset in the fourth L8 cycle aborts the operation
      @(negedge clk);
      setMap(0, 1, 4, 5, 7, 6, 3, 2);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      areset = 1'b0;
      #1;
      checkOutput("abort_state", 32'(state), 32'h0);
      checkOutput("abort_done", 32'(done), 32'h0);
      @(negedge clk);
      areset = 1'b1;
      applyStimulus("after_abort", 0, 1, 2, 3, 4, 5, 6, 7, 20'h00000);
      waitDrain("after_abort");
      repeat (12) @(negedge clk);
      checkOutput("final_state", 32'(state), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
